// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship UART response path.
// Holds the framer state encoding, event record and ASCII codes.
package battleship_pkg;

    typedef enum logic [1:0] {
        FR_IDLE  = 2'd0,
        FR_SEND  = 2'd1,
        FR_GUARD = 2'd2,
        FR_WAIT  = 2'd3
    } framer_state_e;

    localparam logic [7:0] CODE_HIT       = 8'h48;
    localparam logic [7:0] CODE_MISS      = 8'h4D;
    localparam logic [7:0] CODE_REPEAT    = 8'h52;
    localparam logic [7:0] CODE_SUNK      = 8'h53;
    localparam logic [7:0] ASCII_ZERO     = 8'h30;
    localparam logic [7:0] TERM_BYTE_DFLT = 8'h0A;

    localparam int EVT_W = 14;

    typedef struct packed {
        logic [7:0] code;
        logic [2:0] x;
        logic [2:0] y;
    } evt_t;

    // Coordinates are 0-7, so adding to '0' never carries.
    function automatic logic [7:0] msg_byte(
        input evt_t       e,
        input logic [1:0] idx,
        input logic [7:0] term
    );
        logic [7:0] b;
        b = term;
        case (idx)
            2'd0:    b = e.code;
            2'd1:    b = ASCII_ZERO + {5'b0, e.x};
            2'd2:    b = ASCII_ZERO + {5'b0, e.y};
            default: b = term;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/response_tx_framer.sv
// Queues game result events and frames each as a 4-byte ASCII
// message over the UART start/busy handshake.
module response_tx_framer
    import battleship_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] TERM_BYTE = TERM_BYTE_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_valid,
    input  logic [7:0] evt_code,
    input  logic [2:0] evt_x,
    input  logic [2:0] evt_y,
    output logic       evt_ready,
    output logic       overflow,
    output logic [7:0] tx_data_out,
    output logic       tx_start_out,
    input  logic       tx_busy_in,
    output logic       idle
);

    framer_state_e r_state;
    framer_state_e w_state_nxt;
    evt_t          r_msg;
    logic [1:0]    r_idx;
    logic          r_overflow;

    evt_t          w_in_evt;
    logic [EVT_W-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_last;
    logic          w_advance;

    assign w_in_evt = '{code: evt_code, x: evt_x, y: evt_y};

    // Ready tracks only the full flag; a same-cycle pop does not help.
    assign w_push = evt_valid && !w_full;
    assign w_pop  = (r_state == FR_IDLE) && !w_empty;

    assign w_last    = (r_idx == 2'd3);
    assign w_advance = (r_state == FR_WAIT) && !tx_busy_in && !w_last;

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_in_evt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FR_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = FR_SEND;
                end
            end
            FR_SEND:  w_state_nxt = FR_GUARD;
            FR_GUARD: w_state_nxt = FR_WAIT;
            FR_WAIT: begin
                if (!tx_busy_in) begin
                    w_state_nxt = w_last ? FR_IDLE : FR_SEND;
                end
            end
            default:  w_state_nxt = FR_IDLE;
        endcase
    end

    always_comb begin
        tx_start_out = 1'b0;
        tx_data_out  = 8'h00;
        if (r_state == FR_SEND) begin
            tx_start_out = 1'b1;
            tx_data_out  = msg_byte(r_msg, r_idx, TERM_BYTE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg <= '0;
            r_idx <= 2'd0;
        end else if (w_pop) begin
            r_msg <= evt_t'(w_head);
            r_idx <= 2'd0;
        end else if (w_advance) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (evt_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign evt_ready = !w_full;
    assign overflow  = r_overflow;
    assign idle      = (r_state == FR_IDLE) && w_empty;

endmodule

// File: tb/tb_response_tx_framer.sv
// Scoreboard bench for response_tx_framer with a simple UART busy model.
// Expected message bytes are queued at accept time and checked on tx_start.
module tb_response_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic [2:0] evt_x;
    logic [2:0] evt_y;
    logic       evt_ready;
    logic       overflow;
    logic [7:0] tx_data_out;
    logic       tx_start_out;
    logic       tx_busy_in;
    logic       idle;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_start = 0;
    int         busy_len = 10;
    int         bcnt = 0;
    logic       force_busy = 1'b0;
    logic [7:0] sb[$];
    int         start_q[$];
    logic       last_acc;
    int         last_cyc;

    always #5 clk = ~clk;

    response_tx_framer #(
        .DEPTH     (4),
        .TERM_BYTE (8'h0A)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_x        (evt_x),
        .evt_y        (evt_y),
        .evt_ready    (evt_ready),
        .overflow     (overflow),
        .tx_data_out  (tx_data_out),
        .tx_start_out (tx_start_out),
        .tx_busy_in   (tx_busy_in),
        .idle         (idle)
    );

    // UART model: busy from the cycle after a start for busy_len cycles.
    assign tx_busy_in = force_busy || (bcnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start_out && busy_len != 0) begin
            bcnt <= busy_len;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_start_out) begin
            n_start++;
            start_q.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexp_start", sb.size(), 1);
            end else begin
                chk("byte", {24'h0, tx_data_out}, {24'h0, sb.pop_front()});
            end
        end else begin
            chk("data_idle", {24'h0, tx_data_out}, 32'h0);
        end
    end

    task automatic send_evt(input logic [7:0] c, input logic [2:0] x,
                            input logic [2:0] y);
        @(negedge clk);
        evt_valid = 1'b1;
        evt_code  = c;
        evt_x     = x;
        evt_y     = y;
        last_cyc  = cyc;
        last_acc  = evt_ready;
        if (evt_ready) begin
            sb.push_back(c);
            sb.push_back(8'h30 + {5'b0, x});
            sb.push_back(8'h30 + {5'b0, y});
            sb.push_back(8'h0A);
        end
        @(negedge clk);
        evt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(idle && sb.size() == 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("idle", {31'h0, idle}, 1);
        chk("sb_left", sb.size(), 0);
    endtask

    task automatic wait_starts(input int n);
        int k = 0;
        while (n_start < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (n_start < n) begin
            chk("to_start", n_start, n);
        end
    endtask

    initial begin
        int n0;
        int base;
        logic [7:0] codes [4];
        codes[0] = 8'h48;
        codes[1] = 8'h4D;
        codes[2] = 8'h52;
        codes[3] = 8'h53;

        rst       = 1'b1;
        evt_valid = 1'b0;
        evt_code  = 8'h00;
        evt_x     = 3'd0;
        evt_y     = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_idle", {31'h0, idle}, 1);
        chk("rst_ready", {31'h0, evt_ready}, 1);
        chk("rst_ovf", {31'h0, overflow}, 0);
        chk("rst_start", {31'h0, tx_start_out}, 0);
        chk("rst_data", {24'h0, tx_data_out}, 0);

        // Single event, latency and byte order.
        busy_len = 10;
        start_q.delete();
        send_evt(8'h48, 3'd3, 3'd5);
        n0 = last_cyc;
        wait_idle();
        chk("t1_nbytes", start_q.size(), 4);
        if (start_q.size() > 0) begin
            chk("t1_lat", start_q[0] - n0, 2);
        end

        // Hit then sunk three cycles later.
        send_evt(8'h48, 3'd2, 3'd2);
        repeat (2) @(negedge clk);
        send_evt(8'h53, 3'd2, 3'd2);
        wait_idle();
        chk("t2_ovf", {31'h0, overflow}, 0);

        // Six events drained one at a time, wraps the pointers.
        for (int i = 0; i < 6; i++) begin
            send_evt(codes[i % 4], 3'(i), 3'(7 - i));
            wait_idle();
        end

        // Back-to-back spacing with the UART never busy.
        busy_len = 0;
        start_q.delete();
        send_evt(8'h4D, 3'd7, 3'd0);
        wait_idle();
        chk("t6_n", start_q.size(), 4);
        if (start_q.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("t6_gap", start_q[i] - start_q[i-1], 3);
            end
        end
        busy_len = 10;

        // FIFO fill and drop while the UART is held busy.
        base = n_start;
        force_busy = 1'b1;
        send_evt(8'h4D, 3'd1, 3'd1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send_evt(codes[i], 3'(i + 1), 3'(i + 2));
        end
        chk("t3_ready", {31'h0, evt_ready}, 0);
        send_evt(8'h52, 3'd6, 3'd6);
        chk("t3_drop", {31'h0, last_acc}, 0);
        chk("t3_ovf", {31'h0, overflow}, 1);
        force_busy = 1'b0;
        wait_idle();
        chk("t3_bytes", n_start - base, 20);
        chk("t3_ovf_stk", {31'h0, overflow}, 1);

        // Reset during the third byte with two events queued.
        base = n_start;
        send_evt(8'h48, 3'd4, 3'd5);
        send_evt(8'h53, 3'd1, 3'd2);
        send_evt(8'h4D, 3'd3, 3'd3);
        wait_starts(base + 3);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("t5_idle", {31'h0, idle}, 1);
        chk("t5_ready", {31'h0, evt_ready}, 1);
        chk("t5_ovf", {31'h0, overflow}, 0);
        base = n_start;
        repeat (40) @(negedge clk);
        chk("t5_nostart", n_start - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
